// File: rtl/spio_spinnaker_link_transmitter.sv
// SpiNNaker link transmitter: splits 72-bit packets into 4-bit flits and sends
// them 2-of-7 NRZ encoded, one flit per ack transition, followed by an EOP.
module spio_spinnaker_link_transmitter (
    input  logic        CLK_IN,
    input  logic        RESET_IN,
    input  logic [71:0] PKT_DATA_IN,
    input  logic        PKT_VLD_IN,
    output logic        PKT_RDY_OUT,
    output logic [6:0]  SL_DATA_2OF7_OUT,
    input  logic        SL_ACK_IN
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WAIT_EOP
    } state_t;

    localparam logic [6:0] EOP_SYM = 7'b1100000;

    state_t      state;
    logic [71:0] hold_buf;
    logic        hold_full;
    logic [71:0] act_buf;
    logic [4:0]  cnt;
    logic [4:0]  nflits;
    logic        ack_last;

    logic        ack_evt;
    logic        accept;
    logic        load;

    function automatic logic [6:0] sym(input logic [3:0] flit);
        logic [6:0] s;
        case (flit)
            4'h0:    s = 7'b0010001;
            4'h1:    s = 7'b0010010;
            4'h2:    s = 7'b0010100;
            4'h3:    s = 7'b0011000;
            4'h4:    s = 7'b0100001;
            4'h5:    s = 7'b0100010;
            4'h6:    s = 7'b0100100;
            4'h7:    s = 7'b0101000;
            4'h8:    s = 7'b1000001;
            4'h9:    s = 7'b1000010;
            4'hA:    s = 7'b1000100;
            4'hB:    s = 7'b1001000;
            4'hC:    s = 7'b0000011;
            4'hD:    s = 7'b0000110;
            4'hE:    s = 7'b0001100;
            default: s = 7'b0001001;
        endcase
        return s;
    endfunction

    // hold->active transfer happens from IDLE, or straight after the EOP ack
    always_comb begin
        ack_evt = (SL_ACK_IN != ack_last);
        accept  = PKT_VLD_IN && PKT_RDY_OUT;
        load    = hold_full && ((state == IDLE) || ((state == WAIT_EOP) && ack_evt));
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            state            <= IDLE;
            SL_DATA_2OF7_OUT <= '0;
            PKT_RDY_OUT      <= 1'b0;
            hold_buf         <= '0;
            hold_full        <= 1'b0;
            act_buf          <= '0;
            cnt              <= '0;
            nflits           <= '0;
            ack_last         <= SL_ACK_IN;
        end else begin
            ack_last <= SL_ACK_IN;

            if (accept) begin
                hold_buf  <= PKT_DATA_IN;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            PKT_RDY_OUT <= ~(accept || (hold_full && !load));

            if (load) begin
                SL_DATA_2OF7_OUT <= SL_DATA_2OF7_OUT ^ sym(hold_buf[3:0]);
                act_buf          <= {4'h0, hold_buf[71:4]};
                cnt              <= 5'd1;
                nflits           <= hold_buf[1] ? 5'd18 : 5'd10;
                state            <= WAIT;
            end else begin
                case (state)
                    WAIT: begin
                        if (ack_evt) begin
                            if (cnt < nflits) begin
                                SL_DATA_2OF7_OUT <= SL_DATA_2OF7_OUT ^ sym(act_buf[3:0]);
                                act_buf          <= {4'h0, act_buf[71:4]};
                                cnt              <= cnt + 5'd1;
                            end else begin
                                SL_DATA_2OF7_OUT <= SL_DATA_2OF7_OUT ^ EOP_SYM;
                                state            <= WAIT_EOP;
                            end
                        end
                    end
                    WAIT_EOP: begin
                        if (ack_evt) begin
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
